// File: rtl/seq_div_pkg.sv
// ---------------------------------------------------------------------------
// seq_div_pkg
// Shared definitions for the iterative restoring divider (seq_divider).
//   state_t    : FSM encoding {IDLE, CALC, DONE}
//   STATE_W    : width of the state encoding
//   cnt_width(): iteration counter width for a given operand width
//                ($clog2(WIDTH), never less than one bit)
// ---------------------------------------------------------------------------
package seq_div_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage : seq_div_pkg

// File: rtl/seq_divider_full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor cell; a chain of these forms the trial-subtraction
// ripple of seq_divider.
// Ports:
//   a     in  minuend bit
//   b     in  subtrahend bit
//   b_in  in  borrow from the next less significant cell
//   diff  out a - b - b_in (mod 2)
//   b_out out borrow into the next more significant cell
// ---------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  assign diff  = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~a & b_in) | (b & b_in);

endmodule : full_subtractor

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Iterative restoring divider, one quotient bit per clock. Operands are taken
// over a valid/ready handshake, the result is offered over a valid/ready
// handshake and held until consumed.
//
// Configuration macro: SEQ_DIVIDER_SIGNED_EN
//   defined   : two's-complement operands, truncating (toward zero) division;
//               magnitudes are divided and signs fixed on entry to DONE.
//   undefined : unsigned division only.
//
// Parameters:
//   WIDTH        operand / quotient / remainder width (>= 2)
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     dividend/divisor valid
//   in_ready     operands accepted (high only in IDLE)
//   dividend     numerator
//   divisor      denominator
//   out_valid    result valid, held until out_ready
//   out_ready    consumer accepts the result (ignored outside DONE)
//   quotient     result quotient (all ones on divide by zero)
//   remainder    result remainder (dividend on divide by zero)
//   div_by_zero  divisor was zero for this result
// ---------------------------------------------------------------------------
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;   // running partial remainder
  logic [WIDTH-1:0] quo_q;   // dividend bits shift out of the MSB, quotient bits shift in at the LSB
  logic [WIDTH-1:0] div_q;   // captured divisor (magnitude in signed builds)

  // Operand magnitudes presented to the datapath at accept time.
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  // -------------------------------------------------------------------------
  // Trial subtraction: {rem, next dividend bit} - {0, divisor}, WIDTH+1 bits.
  // -------------------------------------------------------------------------
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   subtrahend;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] borrow;

  assign partial    = {rem_q, quo_q[WIDTH-1]};
  assign subtrahend = {1'b0, div_q};
  assign borrow[0]  = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    full_subtractor u_fs (
      .a     (partial[i]),
      .b     (subtrahend[i]),
      .b_in  (borrow[i]),
      .diff  (trial[i]),
      .b_out (borrow[i+1])
    );
  end

  logic             borrow_out;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  // When there is no borrow the trial fits in WIDTH bits, so its MSB is
  // always zero and carries no information.
  logic             unused_trial_msb;

  assign borrow_out       = borrow[WIDTH+1];
  assign unused_trial_msb = trial[WIDTH];
  assign rem_next         = borrow_out ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_next         = {quo_q[WIDTH-2:0], ~borrow_out};

  // Final (sign-corrected) values loaded into the outputs on entry to DONE.
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic neg_q_q;   // quotient negative: operand signs differ
  logic neg_r_q;   // remainder takes the dividend sign
  logic dvd_neg;
  logic dvs_neg;

  assign dvd_neg = dividend[WIDTH-1];
  assign dvs_neg = divisor[WIDTH-1];
  // The most-negative value maps onto itself, which reads correctly as an
  // unsigned magnitude, so no extra bit is needed.
  assign dvd_mag = dvd_neg ? (~dividend + ONE) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + ONE) : divisor;
  assign quo_fix = neg_q_q ? (~quo_next + ONE) : quo_next;
  assign rem_fix = neg_r_q ? (~rem_next + ONE) : rem_next;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign quo_fix = quo_next;
  assign rem_fix = rem_next;
`endif

  // -------------------------------------------------------------------------
  // FSM, iteration counter, shift registers and registered outputs.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt_q       <= '0;
      // NOTE: the working registers are reset too; they are few flops, not a
      // memory, and a defined value keeps a mid-operation reset clean.
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state_q     <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state_q <= CALC;
              cnt_q   <= CNT_LAST;
              rem_q   <= '0;
              quo_q   <= dvd_mag;
              div_q   <= dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
              neg_q_q <= dvd_neg ^ dvs_neg;
              neg_r_q <= dvd_neg;
`endif
            end
          end
        end

        CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (cnt_q == '0) begin
            state_q     <= DONE;
            out_valid   <= 1'b1;
            quotient    <= quo_fix;
            remainder   <= rem_fix;
            div_by_zero <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Directed and random checks of seq_divider (WIDTH = 8). Expected results
// come from a behavioural reference model and are queued when operands are
// driven, then popped when the divider presents its result.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } result_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int tests = 0;
  int failed = 0;

  result_t sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    result_t res;
    int sa, sb_i;
    if (b == '0) begin
      res.q   = '1;
      res.r   = a;
      res.dbz = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa      = int'($signed(a));
      sb_i    = int'($signed(b));
`else
      sa      = int'(a);
      sb_i    = int'(b);
`endif
      res.q   = W'(sa / sb_i);
      res.r   = W'(sa % sb_i);
      res.dbz = 1'b0;
    end
    return res;
  endfunction

  // One complete transaction: accept, latency, result, optional hold in
  // DONE with out_ready low, then release and return to IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    result_t exp;
    int lat;
    int guard;
    int exp_lat;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    exp_lat  = (b == '0) ? 1 : W + 1;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    sb.push_back(model(a, b));
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      // Scramble the inputs after accept; the captured operands must win.
      in_valid = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      if (!out_valid && in_ready)
        check("in_ready_low_busy", 32'(in_ready), 32'd0);
    end while (!out_valid && lat < 50);
    check("latency", 32'(lat), 32'(exp_lat));
    check("out_valid_rise", 32'(out_valid), 32'd1);
    exp = sb.pop_front();
    check("quotient", 32'(quotient), 32'(exp.q));
    check("remainder", 32'(remainder), 32'(exp.r));
    check("div_by_zero", 32'(div_by_zero), 32'(exp.dbz));
    check("in_ready_in_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_quotient", 32'(quotient), 32'(exp.q));
      check("hold_remainder", 32'(remainder), 32'(exp.r));
      check("hold_div_by_zero", 32'(div_by_zero), 32'(exp.dbz));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_div_by_zero", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations
    run_op(8'd200, 8'd7, 0);
    run_op(8'd255, 8'd1, 0);
    run_op(8'd3, 8'd10, 0);
    run_op(8'd0, 8'd9, 0);
    run_op(8'd5, 8'd0, 0);
    run_op(8'd200, 8'd7, 5);
    run_op(8'd5, 8'd0, 3);

    // Reset pulsed in the middle of a calculation
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd3;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_quotient", 32'(quotient), 32'd0);
    check("midreset_remainder", 32'(remainder), 32'd0);
    check("midreset_div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'd100, 8'd3, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_op(8'hF9, 8'd2, 0);    // -7 / 2
    run_op(8'd7, 8'hFE, 0);    //  7 / -2
    run_op(8'h80, 8'hFF, 0);   // -128 / -1
    run_op(8'h80, 8'd0, 0);
    for (int i = 0; i < 1000; i++)
      run_op(W'($urandom), W'($urandom_range(0, 255)), 0);
`else
    for (int i = 0; i < 200; i++)
      run_op(W'($urandom), W'($urandom_range(0, 255)), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_seq_divider
